instruction_fetch: RTL and testbench

Fetch stage of the 24-bit single-cycle CPU. Holds the program counter, requests one 24-bit instruction word per step from instruction memory over a req/ready handshake, and holds it stable for the decode logic and the control unit (OPCODE, Function). Computes the next PC (sequential or BEQ-taken) when downstream signals `Advance`.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_next_pc.sv | 24 ++
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit single-cycle CPU.
// Opcodes, instruction field positions and fetch FSM states.
package cpu_pkg;

    localparam int INSTR_W = 24;

    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LS    = 4'b0010;
    localparam logic [3:0] OP_SS    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b0110;

    localparam int OPC_MSB   = 23;
    localparam int OPC_LSB   = 20;
    localparam int RS_MSB    = 19;
    localparam int RS_LSB    = 16;
    localparam int RT_MSB    = 15;
    localparam int RT_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 8;
    localparam int SHAMT_MSB = 7;
    localparam int SHAMT_LSB = 4;
    localparam int FUNCT_MSB = 3;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 11;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC arithmetic for the fetch stage.
// Immediate arrives already sign-extended/truncated to PC width.
module fetch_next_pc #(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_imm,
    input  logic                i_taken,
    output logic [PC_WIDTH-1:0] o_next_pc,
    output logic [PC_WIDTH-1:0] o_pc_plus1
);

    logic [PC_WIDTH-1:0] w_plus1;
    logic [PC_WIDTH-1:0] w_target;

    // Both paths wrap modulo 2^PC_WIDTH by plain truncation.
    always_comb begin
        w_plus1    = i_pc + PC_WIDTH'(1);
        w_target   = w_plus1 + i_imm;
        o_pc_plus1 = w_plus1;
        o_next_pc  = i_taken ? w_target : w_plus1;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, imem req/ready handshake,
// held instruction word and next-PC update on Advance.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic                ImemReq,
    output logic [PC_WIDTH-1:0] ImemAddr,
    input  logic                ImemReady,
    input  logic [INSTR_W-1:0]  ImemData,
    input  logic                Advance,
    input  logic                Branch,
    input  logic                Zero,
    output logic                InstrValid,
    output logic [INSTR_W-1:0]  Instruction,
    output logic [3:0]          OPCODE,
    output logic [3:0]          Function,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PCPlus1
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [PC_WIDTH-1:0] w_imm;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_pc_plus1;
    logic                w_taken;
    logic                w_capture;
    logic                w_advance;

    // Fit the signed 12-bit immediate to the PC width.
    generate
        if (PC_WIDTH > 12) begin : g_imm_ext
            assign w_imm = {{(PC_WIDTH-12){r_instr[IMM_MSB]}},
                            r_instr[IMM_MSB:IMM_LSB]};
        end else begin : g_imm_trunc
            assign w_imm = r_instr[PC_WIDTH-1:0];
        end
    endgenerate

    assign w_taken   = Branch & Zero;
    assign w_capture = (r_state == FETCH) & ImemReady;
    assign w_advance = (r_state == HOLD) & Advance;

    fetch_next_pc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc (
        .i_pc       (r_pc),
        .i_imm      (w_imm),
        .i_taken    (w_taken),
        .o_next_pc  (w_next_pc),
        .o_pc_plus1 (w_pc_plus1)
    );

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state: IDLE for one cycle, then fetch/hold loop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (ImemReady) w_state_next = HOLD;
            HOLD:    if (Advance)   w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    // PC moves only when downstream consumes the held word.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)          r_pc <= RESET_PC;
        else if (w_advance) r_pc <= w_next_pc;
    end

    // Instruction latches only on the ready edge in FETCH.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)          r_instr <= '0;
        else if (w_capture) r_instr <= ImemData;
    end

    assign ImemReq     = (r_state == FETCH);
    assign ImemAddr    = r_pc;
    assign InstrValid  = (r_state == HOLD);
    assign Instruction = r_instr;
    assign OPCODE      = r_instr[OPC_MSB:OPC_LSB];
    assign Function    = r_instr[FUNCT_MSB:FUNCT_LSB];
    assign PC          = r_pc;
    assign PCPlus1     = w_pc_plus1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch.
// Hand-computed vectors covering handshake, branches, wrap and reset.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ImemReq;
    logic [7:0]  ImemAddr;
    logic        ImemReady;
    logic [23:0] ImemData;
    logic        Advance;
    logic        Branch;
    logic        Zero;
    logic        InstrValid;
    logic [23:0] Instruction;
    logic [3:0]  OPCODE;
    logic [3:0]  Function;
    logic [7:0]  PC;
    logic [7:0]  PCPlus1;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemReady   (ImemReady),
        .ImemData    (ImemData),
        .Advance     (Advance),
        .Branch      (Branch),
        .Zero        (Zero),
        .InstrValid  (InstrValid),
        .Instruction (Instruction),
        .OPCODE      (OPCODE),
        .Function    (Function),
        .PC          (PC),
        .PCPlus1     (PCPlus1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input logic [23:0] word);
        ImemReady = 1'b1;
        ImemData  = word;
        tick();
        ImemReady = 1'b0;
        ImemData  = 24'h0;
    endtask

    task automatic advance(input logic br, input logic z);
        Advance = 1'b1;
        Branch  = br;
        Zero    = z;
        tick();
        Advance = 1'b0;
        Branch  = 1'b0;
        Zero    = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        ImemReady = 1'b1;
        ImemData  = 24'h612345;
        Advance   = 1'b0;
        Branch    = 1'b0;
        Zero      = 1'b0;
        tick();
        tick();
        check("rst_req",   32'(ImemReq), 32'h0);
        check("rst_valid", 32'(InstrValid), 32'h0);
        check("rst_instr", 32'(Instruction), 32'h0);
        check("rst_pc",    32'(PC), 32'h0);
        check("rst_opc",   32'(OPCODE), 32'h0);

        Reset = 1'b0;
        tick();
        check("idle_to_fetch_req",  32'(ImemReq), 32'h1);
        check("idle_to_fetch_addr", 32'(ImemAddr), 32'h0);
        check("idle_valid",         32'(InstrValid), 32'h0);
        tick();
        check("first_valid", 32'(InstrValid), 32'h1);
        check("first_req",   32'(ImemReq), 32'h0);
        check("first_instr", 32'(Instruction), 32'h612345);
        check("first_opc",   32'(OPCODE), 32'h6);
        check("first_func",  32'(Function), 32'h5);
        check("first_pcp1",  32'(PCPlus1), 32'h01);
        ImemReady = 1'b0;

        advance(1'b0, 1'b0);
        check("seq_addr",  32'(ImemAddr), 32'h01);
        check("seq_req",   32'(ImemReq), 32'h1);
        check("seq_valid", 32'(InstrValid), 32'h0);

        for (int i = 0; i < 3; i++) begin
            ImemData = 24'hABCDE0 + 24'(i);
            tick();
            check("wait_req",   32'(ImemReq), 32'h1);
            check("wait_addr",  32'(ImemAddr), 32'h01);
            check("wait_valid", 32'(InstrValid), 32'h0);
            check("wait_instr", 32'(Instruction), 32'h612345);
        end
        fetch(24'h40000E);
        check("wait_cap", 32'(Instruction), 32'h40000E);
        check("wait_vld", 32'(InstrValid), 32'h1);

        advance(1'b1, 1'b1);
        check("jump_to_10", 32'(ImemAddr), 32'h10);

        Advance = 1'b1;
        tick();
        Advance = 1'b0;
        check("adv_in_fetch_req",  32'(ImemReq), 32'h1);
        check("adv_in_fetch_addr", 32'(ImemAddr), 32'h10);
        check("adv_in_fetch_vld",  32'(InstrValid), 32'h0);

        fetch(24'h400FFC);
        ImemReady = 1'b1;
        ImemData  = 24'h111111;
        tick();
        ImemReady = 1'b0;
        check("rdy_in_hold_instr", 32'(Instruction), 32'h400FFC);
        check("rdy_in_hold_vld",   32'(InstrValid), 32'h1);
        check("rdy_in_hold_pc",    32'(PC), 32'h10);

        advance(1'b1, 1'b1);
        check("beq_taken_neg", 32'(ImemAddr), 32'h0D);

        fetch(24'h400002);
        advance(1'b1, 1'b1);
        check("back_to_10", 32'(ImemAddr), 32'h10);
        fetch(24'h400FFC);
        advance(1'b1, 1'b0);
        check("beq_not_taken", 32'(ImemAddr), 32'h11);

        fetch(24'h4000ED);
        advance(1'b1, 1'b1);
        check("jump_to_ff", 32'(ImemAddr), 32'hFF);
        fetch(24'h612345);
        check("pcp1_wrap", 32'(PCPlus1), 32'h00);
        advance(1'b0, 1'b1);
        check("pc_wrap", 32'(ImemAddr), 32'h00);

        fetch(24'h4000FD);
        advance(1'b1, 1'b1);
        check("jump_to_fe", 32'(ImemAddr), 32'hFE);
        fetch(24'h400005);
        advance(1'b1, 1'b1);
        check("beq_wrap", 32'(ImemAddr), 32'h04);

        fetch(24'h40001D);
        advance(1'b1, 1'b1);
        check("jump_to_22", 32'(ImemAddr), 32'h22);
        tick();
        check("mid_fetch_req", 32'(ImemReq), 32'h1);

        #2;
        Reset     = 1'b1;
        ImemReady = 1'b1;
        ImemData  = 24'h777777;
        #1;
        check("async_req",   32'(ImemReq), 32'h0);
        check("async_pc",    32'(PC), 32'h00);
        check("async_valid", 32'(InstrValid), 32'h0);
        check("async_instr", 32'(Instruction), 32'h0);
        tick();
        check("rst_ready_ignored", 32'(Instruction), 32'h0);
        ImemReady = 1'b0;
        Reset     = 1'b0;
        tick();
        check("resume_req",  32'(ImemReq), 32'h1);
        check("resume_addr", 32'(ImemAddr), 32'h00);
        fetch(24'h2ABCDE);
        check("resume_instr", 32'(Instruction), 32'h2ABCDE);
        check("resume_opc",   32'(OPCODE), 32'h2);
        check("resume_func",  32'(Function), 32'hE);
        check("resume_vld",   32'(InstrValid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
